// File: rtl/cntr_dir_decoder.sv
// cntr_dir_decoder
//   Receive-side decoder for the up/down counter's bin_count stream. It samples the
//   count on qualified cycles, recovers the count direction from successive samples,
//   flags illegal steps, tracks lock status and keeps a saturating error tally.
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   reset      in   1      synchronous active-low reset
//   sample_en  in   1      bin_count is valid this cycle
//   bin_count  in   WIDTH  observed counter value
//   dir        out  1      last recovered direction (0 = up, 1 = down)
//   dir_valid  out  1      pulse: dir updated by a legal step
//   hold       out  1      pulse: sample equal to previous sample
//   step_err   out  1      pulse: illegal step detected
//   locked     out  1      level: LOCK_CNT legal steps seen since the last error
//   err_count  out  ERR_W  saturating count of illegal steps
module cntr_dir_decoder #(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned LOCK_CNT = 2,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] bin_count,
   output logic             dir,
   output logic             dir_valid,
   output logic             hold,
   output logic             step_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);

   // Streak counter is sized to reach LOCK_CNT itself without wrapping.
   localparam int unsigned STREAK_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      STEP_UP      = 2'd0,
      STEP_DOWN    = 2'd1,
      STEP_HOLD    = 2'd2,
      STEP_ILLEGAL = 2'd3
   } step_e;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    prev_q, prev_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                dir_q, dir_d;
   logic                dir_valid_q, dir_valid_d;
   logic                hold_q, hold_d;
   logic                step_err_q, step_err_d;
   logic                locked_q, locked_d;
   logic [ERR_W-1:0]    err_q, err_d;

   logic [WIDTH-1:0]    delta_c;
   step_e               step_c;
   logic [STREAK_W-1:0] streak_inc_c;
   logic [ERR_W-1:0]    err_inc_c;

   // Modular difference between the new sample and the previous one.
   always_comb begin
      delta_c = WIDTH'(bin_count - prev_q);
      if (delta_c == WIDTH'(1)) begin
         step_c = STEP_UP;
      end else if (delta_c == {WIDTH{1'b1}}) begin
         step_c = STEP_DOWN;
      end else if (delta_c == '0) begin
         step_c = STEP_HOLD;
      end else begin
         step_c = STEP_ILLEGAL;
      end
   end

   // Error tally stops at all-ones.
   always_comb begin
      streak_inc_c = STREAK_W'(streak_q + 1'b1);
      err_inc_c    = (err_q == {ERR_W{1'b1}}) ? err_q : ERR_W'(err_q + 1'b1);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      streak_d    = streak_q;
      dir_d       = dir_q;
      dir_valid_d = 1'b0;
      hold_d      = 1'b0;
      step_err_d  = 1'b0;
      locked_d    = locked_q;
      err_d       = err_q;

      if (sample_en) begin
         prev_d = bin_count;
         unique case (state_q)
            ST_IDLE: begin
               state_d  = ST_ACQ;
               streak_d = '0;
            end

            ST_ACQ: begin
               unique case (step_c)
                  STEP_UP, STEP_DOWN: begin
                     dir_valid_d = 1'b1;
                     dir_d       = (step_c == STEP_DOWN);
                     streak_d    = streak_inc_c;
                     if (streak_inc_c == STREAK_W'(LOCK_CNT)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                     end
                  end
                  STEP_HOLD: begin
                     hold_d = 1'b1;
                  end
                  default: begin
                     step_err_d = 1'b1;
                     err_d      = err_inc_c;
                     streak_d   = '0;
                  end
               endcase
            end

            ST_LOCKED: begin
               unique case (step_c)
                  STEP_UP, STEP_DOWN: begin
                     dir_valid_d = 1'b1;
                     dir_d       = (step_c == STEP_DOWN);
                  end
                  STEP_HOLD: begin
                     hold_d = 1'b1;
                  end
                  default: begin
                     // Loss of lock lands in the same cycle as the error pulse.
                     step_err_d = 1'b1;
                     err_d      = err_inc_c;
                     streak_d   = '0;
                     state_d    = ST_ACQ;
                     locked_d   = 1'b0;
                  end
               endcase
            end

            default: begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         prev_q      <= '0;
         streak_q    <= '0;
         dir_q       <= 1'b0;
         dir_valid_q <= 1'b0;
         hold_q      <= 1'b0;
         step_err_q  <= 1'b0;
         locked_q    <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         streak_q    <= streak_d;
         dir_q       <= dir_d;
         dir_valid_q <= dir_valid_d;
         hold_q      <= hold_d;
         step_err_q  <= step_err_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
      end
   end

   assign dir       = dir_q;
   assign dir_valid = dir_valid_q;
   assign hold      = hold_q;
   assign step_err  = step_err_q;
   assign locked    = locked_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_cntr_dir_decoder.sv
// Directed bench for cntr_dir_decoder: default instance plus an ERR_W=2 instance
// sharing the same stimulus for the saturation case.
module tb_cntr_dir_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sample_en = 1'b0;
   logic [2:0] bin_count = 3'd0;

   logic       dir, dir_valid, hold, step_err, locked;
   logic [7:0] err_count;
   logic       s_dir, s_dir_valid, s_hold, s_step_err, s_locked;
   logic [1:0] s_err_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cntr_dir_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .sample_en (sample_en),
      .bin_count (bin_count),
      .dir       (dir),
      .dir_valid (dir_valid),
      .hold      (hold),
      .step_err  (step_err),
      .locked    (locked),
      .err_count (err_count)
   );

   cntr_dir_decoder #(.ERR_W(2)) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .sample_en (sample_en),
      .bin_count (bin_count),
      .dir       (s_dir),
      .dir_valid (s_dir_valid),
      .hold      (s_hold),
      .step_err  (s_step_err),
      .locked    (s_locked),
      .err_count (s_err_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock with the given inputs; outputs are observed 1 time unit after the edge.
   task automatic smp(input logic en, input logic [2:0] v);
      @(negedge clk);
      sample_en = en;
      bin_count = v;
      @(posedge clk);
      #1;
   endtask

   // One-cycle reset with sample_en asserted to show reset has priority.
   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b0;
      sample_en = 1'b1;
      bin_count = 3'd3;
      @(posedge clk);
      #1;
      reset     = 1'b1;
      sample_en = 1'b0;
   endtask

   // Expected outputs of the default instance in one compare each.
   task automatic expect_all(input string tag, input logic e_dir, input logic e_dv,
                             input logic e_hold, input logic e_err, input logic e_lock,
                             input logic [7:0] e_cnt);
      check({tag, ".dir"},       32'(dir),       32'(e_dir));
      check({tag, ".dir_valid"}, 32'(dir_valid), 32'(e_dv));
      check({tag, ".hold"},      32'(hold),      32'(e_hold));
      check({tag, ".step_err"},  32'(step_err),  32'(e_err));
      check({tag, ".locked"},    32'(locked),    32'(e_lock));
      check({tag, ".err_count"}, 32'(err_count), 32'(e_cnt));
   endtask

   initial begin
      logic [2:0] v;
      logic       ud;
      logic       last_ud;

      // T1: reset state, then a stream with an error and a reversal, then reset mid-stream
      do_reset();
      expect_all("t1_rst", 0, 0, 0, 0, 0, 8'd0);
      smp(1, 3'd0); expect_all("t1_s0", 0, 0, 0, 0, 0, 8'd0);
      smp(1, 3'd1); expect_all("t1_s1", 0, 1, 0, 0, 0, 8'd0);
      smp(1, 3'd2); expect_all("t1_s2", 0, 1, 0, 0, 1, 8'd0);
      smp(1, 3'd5); expect_all("t1_s5", 0, 0, 0, 1, 0, 8'd1);
      smp(1, 3'd6); expect_all("t1_s6", 0, 1, 0, 0, 0, 8'd1);
      smp(1, 3'd5); expect_all("t1_s5b", 1, 1, 0, 0, 1, 8'd1);
      do_reset();
      expect_all("t1_mid_rst", 0, 0, 0, 0, 0, 8'd0);
      smp(1, 3'd4); expect_all("t1_first", 0, 0, 0, 0, 0, 8'd0);

      // T2: up count across the 7 -> 0 wrap
      do_reset();
      smp(1, 3'd5); expect_all("t2_5", 0, 0, 0, 0, 0, 8'd0);
      smp(1, 3'd6); expect_all("t2_6", 0, 1, 0, 0, 0, 8'd0);
      smp(1, 3'd7); expect_all("t2_7", 0, 1, 0, 0, 1, 8'd0);
      smp(1, 3'd0); expect_all("t2_0", 0, 1, 0, 0, 1, 8'd0);
      smp(1, 3'd1); expect_all("t2_1", 0, 1, 0, 0, 1, 8'd0);

      // T3: down count across the 0 -> 7 wrap
      do_reset();
      smp(1, 3'd1); expect_all("t3_1", 0, 0, 0, 0, 0, 8'd0);
      smp(1, 3'd0); expect_all("t3_0", 1, 1, 0, 0, 0, 8'd0);
      smp(1, 3'd7); expect_all("t3_7", 1, 1, 0, 0, 1, 8'd0);
      smp(1, 3'd6); expect_all("t3_6", 1, 1, 0, 0, 1, 8'd0);

      // T4: skip while locked, then re-lock
      do_reset();
      smp(1, 3'd0);
      smp(1, 3'd1);
      smp(1, 3'd2);
      smp(1, 3'd3); expect_all("t4_3", 0, 1, 0, 0, 1, 8'd0);
      smp(1, 3'd6); expect_all("t4_skip", 0, 0, 0, 1, 0, 8'd1);
      smp(1, 3'd7); expect_all("t4_7", 0, 1, 0, 0, 0, 8'd1);
      smp(1, 3'd0); expect_all("t4_0", 0, 1, 0, 0, 1, 8'd1);

      // T5: hold and sample_en gating (prev must survive the gated cycles)
      smp(1, 3'd1);
      smp(1, 3'd2);
      smp(1, 3'd3);
      smp(1, 3'd4); expect_all("t5_4", 0, 1, 0, 0, 1, 8'd1);
      smp(1, 3'd4); expect_all("t5_hold", 0, 0, 1, 0, 1, 8'd1);
      smp(0, 3'd7); expect_all("t5_gate7", 0, 0, 0, 0, 1, 8'd1);
      smp(0, 3'd2); expect_all("t5_gate2", 0, 0, 0, 0, 1, 8'd1);
      smp(1, 3'd5); expect_all("t5_after", 0, 1, 0, 0, 1, 8'd1);
      smp(1, 3'd4); expect_all("t5_rev", 1, 1, 0, 0, 1, 8'd1);

      // T6: saturation on the ERR_W=2 instance, alternating skips of +3
      do_reset();
      smp(1, 3'd0);
      check("t6_0.err", 32'(s_err_count), 32'd0);
      smp(1, 3'd3);
      check("t6_3.err", 32'(s_err_count), 32'd1);
      check("t6_3.step_err", 32'(s_step_err), 32'd1);
      smp(1, 3'd6);
      check("t6_6.err", 32'(s_err_count), 32'd2);
      check("t6_6.step_err", 32'(s_step_err), 32'd1);
      smp(1, 3'd1);
      check("t6_1.err", 32'(s_err_count), 32'd3);
      check("t6_1.step_err", 32'(s_step_err), 32'd1);
      smp(1, 3'd4);
      check("t6_4.err", 32'(s_err_count), 32'd3);
      check("t6_4.step_err", 32'(s_step_err), 32'd1);
      smp(1, 3'd7);
      check("t6_7.err", 32'(s_err_count), 32'd3);
      check("t6_7.step_err", 32'(s_step_err), 32'd1);
      check("t6_7.locked", 32'(s_locked), 32'd0);
      check("t6_wide.err", 32'(err_count), 32'd5);

      // Random direction as the counter would drive it, with occasional idle cycles
      do_reset();
      v = 3'($urandom_range(0, 7));
      smp(1, v);
      last_ud = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            smp(0, 3'($urandom_range(0, 7)));
            check("rnd_gap.dir", 32'(dir), 32'(last_ud));
            check("rnd_gap.dv", 32'(dir_valid), 32'd0);
         end else begin
            ud = 1'($urandom_range(0, 1));
            v  = ud ? 3'(v - 3'd1) : 3'(v + 3'd1);
            smp(1, v);
            last_ud = ud;
            check("rnd.dir", 32'(dir), 32'(ud));
            check("rnd.dv", 32'(dir_valid), 32'd1);
         end
      end
      check("rnd.err", 32'(err_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
